arbitro_bus_memoria: RTL and testbench

Two-master arbiter and access sequencer for the single 16-bit memory port. Master 0 is the CPU: the control unit's fetch/AR/DR path. Master 1 is the DMA/peripheral port. The block grants the port, drives address, data and strobes for a fixed number of wait states, captures read data and returns a one-cycle acknowledge. CPU has priority, with a bounded-starvation rule for DMA.

---
 rtl/arbitro_bus_memoria.sv | 110 +++++++++++
 tb/tb_arbitro_bus_memoria.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_bus_memoria.sv
// Two-master arbiter and access sequencer for the single memory port.
// CPU has priority; DMA is guaranteed a grant after MAX_RACHA back-to-back CPU grants.
module arbitro_bus_memoria #(
  parameter int ANCHO_DATOS = 16,
  parameter int ANCHO_DIR   = 16,
  parameter int ESPERA      = 2,
  parameter int MAX_RACHA   = 4
) (
  input  logic                   Reloj,
  input  logic                   Reiniciar,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ANCHO_DIR-1:0]   cpu_dir,
  input  logic [ANCHO_DATOS-1:0] cpu_dato_esc,
  output logic                   cpu_ack,
  input  logic                   dma_req,
  input  logic                   dma_we,
  input  logic [ANCHO_DIR-1:0]   dma_dir,
  input  logic [ANCHO_DATOS-1:0] dma_dato_esc,
  output logic                   dma_ack,
  output logic [ANCHO_DATOS-1:0] dato_leido,
  output logic [ANCHO_DIR-1:0]   mem_dir,
  output logic [ANCHO_DATOS-1:0] mem_dato_esc,
  input  logic [ANCHO_DATOS-1:0] mem_dato_lec,
  output logic                   mem_ce,
  output logic                   mem_we,
  output logic                   ocupado,
  output logic                   concesion
);

  typedef enum logic [1:0] {LIBRE, ACCESO, RESP} tEstado;

  localparam logic [3:0] esperaIni = 4'(ESPERA);
  localparam logic [3:0] rachaMax  = 4'(MAX_RACHA);

  tEstado     estado;
  logic [3:0] contador;
  logic [3:0] racha;
  logic       weLatch;
  logic       cpuGana;

  // DMA only overrides the CPU once the CPU has used up its streak.
  always_comb cpuGana = cpu_req && !(dma_req && (racha == rachaMax));

  always_ff @(posedge Reloj) begin
    // NOTE: reset is sampled synchronously and checked first, so it aborts any access in flight.
    if (Reiniciar) begin
      estado       <= LIBRE;
      contador     <= '0;
      racha        <= '0;
      weLatch      <= 1'b0;
      cpu_ack      <= 1'b0;
      dma_ack      <= 1'b0;
      dato_leido   <= '0;
      mem_dir      <= '0;
      mem_dato_esc <= '0;
      mem_ce       <= 1'b0;
      mem_we       <= 1'b0;
      ocupado      <= 1'b0;
      concesion    <= 1'b0;
    end else begin
      case (estado)
        LIBRE: begin
          if (cpu_req || dma_req) begin
            estado   <= ACCESO;
            contador <= esperaIni;
            mem_ce   <= 1'b1;
            ocupado  <= 1'b1;
            if (cpuGana) begin
              concesion    <= 1'b0;
              mem_dir      <= cpu_dir;
              mem_dato_esc <= cpu_dato_esc;
              weLatch      <= cpu_we;
              mem_we       <= cpu_we;
              // A contested CPU win implies racha < rachaMax, so this never overflows.
              racha        <= dma_req ? racha + 4'd1 : 4'd0;
            end else begin
              concesion    <= 1'b1;
              mem_dir      <= dma_dir;
              mem_dato_esc <= dma_dato_esc;
              weLatch      <= dma_we;
              mem_we       <= dma_we;
              racha        <= '0;
            end
          end
        end
        ACCESO: begin
          if (contador == 4'd0) begin
            estado  <= RESP;
            mem_ce  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= !concesion;
            dma_ack <= concesion;
            if (!weLatch) dato_leido <= mem_dato_lec;
          end else begin
            contador <= contador - 4'd1;
          end
        end
        RESP: begin
          estado  <= LIBRE;
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          ocupado <= 1'b0;
        end
        default: estado <= LIBRE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_bus_memoria.sv
// Directed bench for arbitro_bus_memoria: one instance with ESPERA=2, one with ESPERA=0.
module tb_arbitro_bus_memoria;

  logic        Reloj = 1'b0;
  logic        Reiniciar;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_dir, cpu_dato_esc;
  logic        dma_req, dma_we, dma_ack;
  logic [15:0] dma_dir, dma_dato_esc;
  logic [15:0] dato_leido, mem_dir, mem_dato_esc, mem_dato_lec;
  logic        mem_ce, mem_we, ocupado, concesion;

  logic        zCpuReq, zCpuAck, zDmaAck, zMemCe, zMemWe, zOcupado, zConcesion;
  logic [15:0] zDatoLeido, zMemDir, zMemDatoEsc, zMemDatoLec;

  int checks = 0;
  int errors = 0;

  always #5 Reloj = ~Reloj;

  // Memory model: one fixed word, everything else derived from the address.
  function automatic logic [15:0] memModel(input logic [15:0] dir);
    return (dir == 16'h0010) ? 16'hBEEF : (dir ^ 16'hA5A5);
  endfunction

  assign mem_dato_lec = memModel(mem_dir);
  assign zMemDatoLec  = memModel(zMemDir);

  arbitro_bus_memoria #(.ANCHO_DATOS(16), .ANCHO_DIR(16), .ESPERA(2), .MAX_RACHA(4)) dut (
    .Reloj(Reloj), .Reiniciar(Reiniciar),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_dir(cpu_dir), .cpu_dato_esc(cpu_dato_esc),
    .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_dir(dma_dir), .dma_dato_esc(dma_dato_esc),
    .dma_ack(dma_ack),
    .dato_leido(dato_leido), .mem_dir(mem_dir), .mem_dato_esc(mem_dato_esc),
    .mem_dato_lec(mem_dato_lec), .mem_ce(mem_ce), .mem_we(mem_we),
    .ocupado(ocupado), .concesion(concesion)
  );

  arbitro_bus_memoria #(.ANCHO_DATOS(16), .ANCHO_DIR(16), .ESPERA(0), .MAX_RACHA(4)) dutZ (
    .Reloj(Reloj), .Reiniciar(Reiniciar),
    .cpu_req(zCpuReq), .cpu_we(1'b0), .cpu_dir(16'h0010), .cpu_dato_esc(16'h0000),
    .cpu_ack(zCpuAck),
    .dma_req(1'b0), .dma_we(1'b0), .dma_dir(16'h0000), .dma_dato_esc(16'h0000),
    .dma_ack(zDmaAck),
    .dato_leido(zDatoLeido), .mem_dir(zMemDir), .mem_dato_esc(zMemDatoEsc),
    .mem_dato_lec(zMemDatoLec), .mem_ce(zMemCe), .mem_we(zMemWe),
    .ocupado(zOcupado), .concesion(zConcesion)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Reloj);
    #1;
  endtask

  // Runs one access for a single master: counts edges until its ack, counts strobe
  // cycles, and flags unstable address/data/we, wrong owner or a stray ack.
  task automatic doAccess(input bit isDma, input bit we, input logic [15:0] dir,
                          input logic [15:0] dat, output int lat, output int ceCnt,
                          output int bad);
    bit done = 1'b0;
    lat = 0; ceCnt = 0; bad = 0;
    if (isDma) begin
      dma_we = we; dma_dir = dir; dma_dato_esc = dat; dma_req = 1'b1;
    end else begin
      cpu_we = we; cpu_dir = dir; cpu_dato_esc = dat; cpu_req = 1'b1;
    end
    while (!done && lat < 30) begin
      tick();
      lat++;
      if (mem_ce) begin
        ceCnt++;
        if (mem_dir !== dir || mem_we !== we || (we && mem_dato_esc !== dat) ||
            concesion !== isDma) bad++;
      end
      if (isDma ? cpu_ack : dma_ack) bad++;
      if (isDma ? dma_ack : cpu_ack) done = 1'b1;
    end
    if (!done) lat = -1;
    if (isDma) dma_req = 1'b0; else cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, ceCnt, bad, waited, gaps, ackSeen;
    logic [9:0] expOrden;

    Reiniciar = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_dir = '0; cpu_dato_esc = '0;
    dma_req = 0; dma_we = 0; dma_dir = '0; dma_dato_esc = '0;
    zCpuReq = 0;
    tick(); tick();
    Reiniciar = 1'b0;
    check("reset outputs",
          {cpu_ack, dma_ack, dato_leido, mem_dir, mem_dato_esc, mem_ce, mem_we, ocupado, concesion},
          '0);

    // CPU read, ESPERA=2
    doAccess(0, 0, 16'h0010, 16'h0000, lat, ceCnt, bad);
    check("cpu read latency", lat, 4);
    check("cpu read ce cycles", ceCnt, 3);
    check("cpu read bus stable", bad, 0);
    check("cpu read data", dato_leido, 16'hBEEF);
    check("cpu read owner", concesion, 0);
    tick();
    check("cpu ack one cycle", {cpu_ack, dma_ack, ocupado, mem_ce}, 4'b0000);

    // DMA write keeps dato_leido
    doAccess(1, 1, 16'h00FF, 16'h1234, lat, ceCnt, bad);
    check("dma write latency", lat, 4);
    check("dma write ce cycles", ceCnt, 3);
    check("dma write bus stable", bad, 0);
    check("dma write owner", concesion, 1);
    check("dma write keeps data", dato_leido, 16'hBEEF);
    tick();
    check("dma ack one cycle", {cpu_ack, dma_ack}, 2'b00);

    // Simultaneous first requests: CPU wins, DMA follows after one LIBRE cycle
    dma_we = 1; dma_dir = 16'h0040; dma_dato_esc = 16'h5555; dma_req = 1'b1;
    doAccess(0, 0, 16'h0030, 16'h0000, lat, ceCnt, bad);
    check("tie cpu wins latency", lat, 4);
    check("tie cpu read data", dato_leido, 16'h0030 ^ 16'hA5A5);
    tick();
    check("gap after cpu ack", {ocupado, mem_ce}, 2'b00);
    tick();
    check("dma granted after cpu",
          {mem_ce, mem_we, concesion, mem_dir, mem_dato_esc}, {3'b111, 16'h0040, 16'h5555});
    waited = 0;
    while (!dma_ack && waited < 20) begin tick(); waited++; end
    check("dma ack after cpu", dma_ack, 1);
    dma_req = 1'b0;
    tick(); tick();

    // Starvation bound: both requests held continuously
    expOrden = 10'b10_0001_0000;
    cpu_we = 0; cpu_dir = 16'h0050; cpu_req = 1'b1;
    dma_we = 1; dma_dir = 16'h0060; dma_dato_esc = 16'h0A0A; dma_req = 1'b1;
    gaps = 0;
    for (int g = 0; g < 10; g++) begin
      waited = 0;
      while (!(cpu_ack || dma_ack) && waited < 20) begin tick(); waited++; end
      ackSeen = cpu_ack || dma_ack;
      check($sformatf("grant %0d ack seen", g), ackSeen, 1);
      if (!ackSeen) break;
      check($sformatf("grant %0d owner", g), {dma_ack, cpu_ack, concesion},
            {expOrden[g], ~expOrden[g], expOrden[g]});
      tick();
      if (!ocupado && !mem_ce) gaps++;
    end
    check("libre gap between accesses", gaps, 10);
    cpu_req = 1'b0; dma_req = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();

    // Reset in the second ACCESO cycle of a read
    cpu_we = 0; cpu_dir = 16'h0020; cpu_req = 1'b1;
    tick(); tick();
    check("in access before reset", {mem_ce, mem_dir}, {1'b1, 16'h0020});
    Reiniciar = 1'b1;
    tick();
    Reiniciar = 1'b0; cpu_req = 1'b0;
    check("abort outputs",
          {cpu_ack, dma_ack, dato_leido, mem_dir, mem_dato_esc, mem_ce, mem_we, ocupado, concesion},
          '0);
    ackSeen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_ack || dma_ack || mem_ce) ackSeen++;
    end
    check("no ack after abort", ackSeen, 0);
    doAccess(0, 0, 16'h0010, 16'h0000, lat, ceCnt, bad);
    check("fresh read latency", lat, 4);
    check("fresh read data", dato_leido, 16'hBEEF);
    tick();

    // ESPERA=0 instance
    zCpuReq = 1'b1;
    lat = 0; ceCnt = 0;
    while (!zCpuAck && lat < 20) begin
      tick(); lat++;
      if (zMemCe) ceCnt++;
    end
    zCpuReq = 1'b0;
    check("espera0 latency", lat, 2);
    check("espera0 ce cycles", ceCnt, 1);
    check("espera0 data", {zDatoLeido, zDmaAck, zConcesion}, {16'hBEEF, 2'b00});
    tick();
    check("espera0 ack one cycle", {zCpuAck, zOcupado, zMemWe}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
